fa16_phase_sequencer: RTL

// - Digital front/back end for the 16-bit dual-rail reversible adder macro.
// - Accepts operands over a valid/ready handshake and drives the macro's b, a_f, c0_f

---
 rtl/fa16_phase_sequencer_pkg.sv | 10 +
 rtl/fa16_phase_sequencer_if.sv | 18 +
 rtl/fa16_phase_sequencer_rail_sync2.sv | 23 ++
 rtl/fa16_phase_sequencer.sv | 123 ++++++++++++
 4 files changed

// File: rtl/fa16_phase_sequencer_pkg.sv
// fa16_seq_pkg: shared types and rail helpers for the fa16 phase sequencer
package fa16_seq_pkg;
   localparam int SEQ_WIDTH = 16;
   typedef enum logic [2:0] {IDLE, SETUP, FWD, CAPT, RELF, BWD, REL} state_t;
   typedef struct packed {logic p; logic n;} rail_t;
   localparam rail_t RAIL_NULL = '{p: 1'b0, n: 1'b0};
   function automatic rail_t to_rail(input logic v);
      return '{p: v, n: ~v};
   endfunction
endpackage

// File: rtl/fa16_phase_sequencer_if.sv
// fa16_phase_sequencer_if: operand request and result return handshakes
interface fa16_phase_sequencer_if import fa16_seq_pkg::*; #(parameter int WIDTH = SEQ_WIDTH);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
   logic             out_cout;
   logic             out_z;
   logic             out_err;
   modport master (output in_valid, in_a, in_b, in_cin, out_ready,
                   input in_ready, out_valid, out_sum, out_cout, out_z, out_err);
   modport slave (input in_valid, in_a, in_b, in_cin, out_ready,
                  output in_ready, out_valid, out_sum, out_cout, out_z, out_err);
endinterface

// File: rtl/fa16_phase_sequencer_rail_sync2.sv
// rail_sync2: two-flop synchroniser on N rail pairs, resets to NULL
module rail_sync2 #(parameter int N = 18) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] d_p,
   input  logic [N-1:0] d_n,
   output logic [N-1:0] q_p,
   output logic [N-1:0] q_n
);
   logic [N-1:0] m_p, m_n;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         m_p <= '0;
         m_n <= '0;
         q_p <= '0;
         q_n <= '0;
      end else begin
         m_p <= d_p;
         m_n <= d_n;
         q_p <= m_p;
         q_n <= m_n;
      end
endmodule

// File: rtl/fa16_phase_sequencer.sv
// fa16_phase_sequencer: drives the dual-rail adder macro phases and returns its result
module fa16_phase_sequencer import fa16_seq_pkg::*; #(
   parameter int WIDTH      = SEQ_WIDTH,
   parameter int SETUP_CYC  = 1,
   parameter int EVAL_CYC   = 2,
   parameter int UNCOMP_CYC = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   fa16_phase_sequencer_if.slave  io,
   output logic                   busy,
   output logic [WIDTH-1:0]       b_p,
   output logic [WIDTH-1:0]       b_n,
   output logic [WIDTH-1:0]       af_p,
   output logic [WIDTH-1:0]       af_n,
   output logic                   c0f_p,
   output logic                   c0f_n,
   output logic [WIDTH-1:0]       ab_p,
   output logic [WIDTH-1:0]       ab_n,
   output logic                   c0b_p,
   output logic                   c0b_n,
   input  logic [WIDTH-1:0]       s_p,
   input  logic [WIDTH-1:0]       s_n,
   input  logic                   c15_p,
   input  logic                   c15_n,
   input  logic                   z_p,
   input  logic                   z_n
);
   localparam int MAX_SE = SETUP_CYC > EVAL_CYC ? SETUP_CYC : EVAL_CYC;
   localparam int MAXC   = MAX_SE > UNCOMP_CYC ? MAX_SE : UNCOMP_CYC;
   localparam int CW     = $clog2(MAXC) > 0 ? $clog2(MAXC) : 1;
   state_t           state, state_nx;
   logic [CW-1:0]    cnt, cnt_nx;
   logic [WIDTH-1:0] op_a, op_b, b_val;
   logic             op_cin, accept, b_on, f_on, k_on;
   rail_t            c0f_r, c0b_r;
   logic [WIDTH+1:0] sy_p, sy_n;
   assign io.in_ready = (state == IDLE) && (!io.out_valid || io.out_ready);
   assign accept      = io.in_valid && io.in_ready;
   assign busy        = state != IDLE;
   assign {c0f_p, c0f_n} = c0f_r;
   assign {c0b_p, c0b_n} = c0b_r;
   rail_sync2 #(.N(WIDTH + 2)) u_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .d_p  ({z_p, c15_p, s_p}),
      .d_n  ({z_n, c15_n, s_n}),
      .q_p  (sy_p),
      .q_n  (sy_n)
   );
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt - CW'(1);
      unique case (state)
         IDLE: begin
            state_nx = accept ? SETUP : IDLE;
            cnt_nx   = CW'(SETUP_CYC - 1);
         end
         SETUP: if (cnt == '0) begin
            state_nx = FWD;
            cnt_nx   = CW'(EVAL_CYC - 1);
         end
         FWD:  if (cnt == '0) state_nx = CAPT;
         CAPT: state_nx = RELF;
         RELF: begin
            state_nx = BWD;
            cnt_nx   = CW'(UNCOMP_CYC - 1);
         end
         BWD:  if (cnt == '0) state_nx = REL;
         REL:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end
   // rails are registered from the next state so every pair changes only through NULL
   assign b_on  = state_nx inside {SETUP, FWD, CAPT, RELF, BWD};
   assign f_on  = state_nx inside {FWD, CAPT};
   assign k_on  = state_nx == BWD;
   assign b_val = accept ? io.in_b : op_b;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state        <= IDLE;
         cnt          <= '0;
         op_a         <= '0;
         op_b         <= '0;
         op_cin       <= 1'b0;
         b_p          <= '0;
         b_n          <= '0;
         af_p         <= '0;
         af_n         <= '0;
         ab_p         <= '0;
         ab_n         <= '0;
         c0f_r        <= RAIL_NULL;
         c0b_r        <= RAIL_NULL;
         io.out_valid <= 1'b0;
         io.out_sum   <= '0;
         io.out_cout  <= 1'b0;
         io.out_z     <= 1'b0;
         io.out_err   <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         if (accept) begin
            op_a   <= io.in_a;
            op_b   <= io.in_b;
            op_cin <= io.in_cin;
         end
         b_p   <= b_on ? b_val : '0;
         b_n   <= b_on ? ~b_val : '0;
         af_p  <= f_on ? op_a : '0;
         af_n  <= f_on ? ~op_a : '0;
         c0f_r <= f_on ? to_rail(op_cin) : RAIL_NULL;
         ab_p  <= k_on ? op_a : '0;
         ab_n  <= k_on ? ~op_a : '0;
         c0b_r <= k_on ? to_rail(op_cin) : RAIL_NULL;
         if (state == CAPT) begin
            io.out_sum  <= sy_p[WIDTH-1:0];
            io.out_cout <= sy_p[WIDTH];
            io.out_z    <= sy_p[WIDTH+1];
            io.out_err  <= |(sy_p ~^ sy_n);
         end
         io.out_valid <= (state == CAPT) || (io.out_valid && !io.out_ready);
      end
endmodule
